// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic pipeline-stage register for the RV32 pipeline (IF/ID, ID/EX,
//   EX/MEM, MEM/WB). It carries a datapath bundle and a control bundle with a
//   valid/ready handshake, a synchronous flush, and an optional 2-entry skid.
//   The control bundle reads all-zero whenever no entry is presented.
//
//   Parameters
//     DATA_W  width of the datapath bundle
//     CTRL_W  width of the control bundle
//     SKID    1: 2-entry skid, in_ready registered; 0: 1 entry, in_ready comb
//     CNT_W   width of the performance counters
//
//   Ports
//     clk, rst            clock (rising edge), async active-low reset
//     flush               synchronous kill of all held entries
//     in_valid/in_ready   upstream handshake; in_data, in_ctrl upstream bundle
//     out_valid/out_ready downstream handshake; out_data, out_ctrl held bundle
//     occupancy           entries held (0..2)
//     stall_cnt           cycles with out_valid & ~out_ready (saturating)
//     flush_cnt           flushes that discarded at least one entry (saturating)
//
//   Build option
//     PIPE_STAGE_PERF_EN  builds the saturating stall/flush counters; when it is
//                         not defined both counters read as constant zero.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encoding equals the number of held entries, so occupancy decodes directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;

  logic in_xfer, out_xfer;
  logic ld_m_in;    // main entry takes the upstream bundle
  logic ld_m_skid;  // main entry takes the skid entry
  logic ld_s;       // skid entry takes the upstream bundle
  logic clr_m;      // main control cleared: stage goes empty

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Next-state and datapath load decode
  always_comb begin
    state_nxt = state;
    ld_m_in   = 1'b0;
    ld_m_skid = 1'b0;
    ld_s      = 1'b0;
    clr_m     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      clr_m     = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
            ld_m_in   = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            ld_m_in = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: without a skid in_ready needs out_ready.
            state_nxt = TWO;
            ld_s      = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
            clr_m     = 1'b1;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_nxt = ONE;
            ld_m_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
          clr_m     = 1'b1;
        end
      endcase
    end
  end

  // Output decode; in_ready never depends on flush.
  always_comb begin
    out_valid = (state != EMPTY);
    occupancy = state;
    if (SKID != 0) in_ready = (state != TWO);
    else           in_ready = (state == EMPTY) || out_ready;
  end

  // Held entries. The main control register is zeroed whenever the stage
  // empties, so out_ctrl is driven straight from a flop and cannot glitch;
  // the main datapath keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else begin
      if (ld_m_in) begin
        m_data <= in_data;
        m_ctrl <= in_ctrl;
      end else if (ld_m_skid) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end else if (clr_m) begin
        m_ctrl <= '0;
      end
      if (ld_s) begin
        s_data <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end

  assign out_data = m_data;
  assign out_ctrl = m_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (flush && (state != EMPTY) && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1, CNT_W=4 instance
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [11:0] in_ctrl;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [11:0] out_ctrl;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt, flush_cnt;

  // SKID=0 instance
  logic        flush0, in_valid0, out_ready0;
  logic [63:0] in_data0;
  logic [11:0] in_ctrl0;
  logic        in_ready0, out_valid0;
  logic [63:0] out_data0;
  logic [11:0] out_ctrl0;
  logic [1:0]  occupancy0;
  logic [15:0] stall_cnt0, flush_cnt0;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(12), .SKID(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(12), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] d, input logic [11:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  logic [63:0] q[$];
  logic [63:0] exp_d;
  int sent, recv;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_out_ctrl",  64'(out_ctrl), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    step();
    rst = 1'b1;

    // 1: single entry, one-cycle latency
    push(64'h1234, 12'h0A5);
    out_ready = 1'b1;
    #1 check("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_data",  out_data, 64'h1234);
    check("t1_out_ctrl",  64'(out_ctrl), 64'h0A5);
    check("t1_occupancy", 64'(occupancy), 64'd1);
    step();
    check("t1_bubble_valid", 64'(out_valid), 64'd0);
    check("t1_bubble_ctrl",  64'(out_ctrl), 64'd0);
    check("t1_bubble_data",  out_data, 64'h1234);
    check("t1_bubble_occ",   64'(occupancy), 64'd0);

    // 2: skid fill, third push refused, drain in order
    out_ready = 1'b0;
    push(64'hAAAA_0001, 12'h001);
    step();
    check("t2_occ_one",    64'(occupancy), 64'd1);
    check("t2_ready_one",  64'(in_ready), 64'd1);
    push(64'hBBBB_0002, 12'h002);
    step();
    check("t2_occ_two",    64'(occupancy), 64'd2);
    check("t2_ready_two",  64'(in_ready), 64'd0);
    check("t2_head_data",  out_data, 64'hAAAA_0001);
    check("t2_head_ctrl",  64'(out_ctrl), 64'h001);
    push(64'hCCCC_0003, 12'h003);
    step();
    check("t2_occ_hold",   64'(occupancy), 64'd2);
    check("t2_head_hold",  out_data, 64'hAAAA_0001);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("t2_b_data",     out_data, 64'hBBBB_0002);
    check("t2_b_ctrl",     64'(out_ctrl), 64'h002);
    check("t2_b_occ",      64'(occupancy), 64'd1);
    check("t2_b_ready",    64'(in_ready), 64'd1);
    step();
    check("t2_empty_valid", 64'(out_valid), 64'd0);
    check("t2_empty_ctrl",  64'(out_ctrl), 64'd0);
    check("t2_empty_data",  out_data, 64'hBBBB_0002);

    // 3: flush from TWO, from ONE, and while empty
    out_ready = 1'b0;
    push(64'hD, 12'h00D);
    step();
    push(64'hE, 12'h00E);
    step();
    check("t3_occ_two", 64'(occupancy), 64'd2);
    flush = 1'b1;
    push(64'hF, 12'h00F);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t3_flush_valid", 64'(out_valid), 64'd0);
    check("t3_flush_ctrl",  64'(out_ctrl), 64'd0);
    check("t3_flush_occ",   64'(occupancy), 64'd0);
    check("t3_flush_cnt1",  64'(flush_cnt), PERF ? 64'd1 : 64'd0);
    push(64'h10, 12'h010);
    step();
    check("t3_occ_one", 64'(occupancy), 64'd1);
    flush = 1'b1;
    push(64'h11, 12'h011);
    out_ready = 1'b1;
    #1 check("t3_ready_in_flush", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t3_discard_valid", 64'(out_valid), 64'd0);
    check("t3_discard_occ",   64'(occupancy), 64'd0);
    check("t3_flush_cnt2",    64'(flush_cnt), PERF ? 64'd2 : 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_empty_flush_cnt", 64'(flush_cnt), PERF ? 64'd2 : 64'd0);

    // 5: stall counter saturates at 15 with CNT_W=4
    #2 rst = 1'b0;
    #1 check("t5_rst_stall", 64'(stall_cnt), 64'd0);
    check("t5_rst_flush", 64'(flush_cnt), 64'd0);
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    push(64'h4A, 12'h04A);
    step();
    in_valid = 1'b0;
    check("t5_stall0", 64'(stall_cnt), 64'd0);
    repeat (5) step();
    check("t5_stall5", 64'(stall_cnt), PERF ? 64'd5 : 64'd0);
    repeat (15) step();
    check("t5_stall_sat", 64'(stall_cnt), PERF ? 64'd15 : 64'd0);
    check("t5_head_data", out_data, 64'h4A);

    // 6: async reset while TWO, then one-cycle latency
    push(64'h4B, 12'h04B);
    step();
    in_valid = 1'b0;
    check("t6_occ_two", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_ctrl",  64'(out_ctrl), 64'd0);
    check("t6_rst_data",  out_data, 64'd0);
    check("t6_rst_occ",   64'(occupancy), 64'd0);
    check("t6_rst_stall", 64'(stall_cnt), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b1;
    push(64'h4C, 12'h04C);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_lat_valid", 64'(out_valid), 64'd1);
    check("t6_lat_data",  out_data, 64'h4C);
    check("t6_lat_ctrl",  64'(out_ctrl), 64'h04C);
    step();

    // 4: stream 100 entries with random backpressure
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 2000 && recv < 100; cyc++) begin
      in_valid  = (sent < 100);
      in_data   = 64'hC0DE_0000_0000_0000 | 64'(sent);
      in_ctrl   = 12'(sent) ^ 12'h5A5;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 64'hDEAD;
        check("t4_data", out_data, exp_d);
        check("t4_ctrl", 64'(out_ctrl), 64'(exp_d[11:0] ^ 12'h5A5));
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    check("t4_recv_count", 64'(recv), 64'd100);
    check("t4_queue_empty", 64'(q.size()), 64'd0);

    // SKID=0: combinational in_ready, no second entry
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_data0   = 64'h5000;
    in_ctrl0   = 12'h050;
    #1 check("s0_ready_empty", 64'(in_ready0), 64'd1);
    step();
    check("s0_occ_one",   64'(occupancy0), 64'd1);
    check("s0_valid",     64'(out_valid0), 64'd1);
    check("s0_ready_full", 64'(in_ready0), 64'd0);
    in_data0 = 64'h6000;
    in_ctrl0 = 12'h060;
    step();
    check("s0_hold_data", out_data0, 64'h5000);
    check("s0_hold_occ",  64'(occupancy0), 64'd1);
    out_ready0 = 1'b1;
    #1 check("s0_ready_comb", 64'(in_ready0), 64'd1);
    step();
    in_valid0 = 1'b0;
    check("s0_y_data", out_data0, 64'h6000);
    check("s0_y_ctrl", 64'(out_ctrl0), 64'h060);
    check("s0_y_occ",  64'(occupancy0), 64'd1);
    step();
    check("s0_empty_valid", 64'(out_valid0), 64'd0);
    check("s0_empty_ctrl",  64'(out_ctrl0), 64'd0);
    check("s0_empty_data",  out_data0, 64'h6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
